// File: rtl/axi_read_arbiter.sv
// Three-master AXI read arbiter: fixed priority m0 > m1 > m2 with a cap on consecutive m0 wins.
// A grant covers one whole transaction, from the AR handshake through the RLAST beat.
module axi_read_arbiter #(
    parameter int unsigned ADDR_W       = 32,
    parameter int unsigned DATA_W       = 32,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [2:0]            m_arvalid,
    output logic [2:0]            m_arready,
    input  logic [3*ADDR_W-1:0]   m_araddr,
    input  logic [23:0]           m_arlen,
    input  logic [8:0]            m_arsize,
    input  logic [5:0]            m_arburst,
    output logic [2:0]            m_rvalid,
    input  logic [2:0]            m_rready,
    output logic [DATA_W-1:0]     m_rdata,
    output logic [1:0]            m_rresp,
    output logic                  m_rlast,
    output logic                  s_arvalid,
    input  logic                  s_arready,
    output logic [ADDR_W-1:0]     s_araddr,
    output logic [7:0]            s_arlen,
    output logic [2:0]            s_arsize,
    output logic [1:0]            s_arburst,
    input  logic                  s_rvalid,
    output logic                  s_rready,
    input  logic [DATA_W-1:0]     s_rdata,
    input  logic [1:0]            s_rresp,
    input  logic                  s_rlast,
    output logic [2:0]            grnt,
    output logic                  busy
);

    typedef enum logic [1:0] {StIdle, StAddr, StData} state_e;

    localparam logic [3:0] Limit = 4'(STARVE_LIMIT);

    state_e     state_q, state_d;
    logic [1:0] owner_q, owner_d;
    logic [3:0] win_cnt_q, win_cnt_d;
    logic [1:0] sel;
    logic       others_req;
    logic [2:0] owner_oh;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            owner_q   <= 2'd0;
            win_cnt_q <= 4'd0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            win_cnt_q <= win_cnt_d;
        end
    end

    // Once m0 has used up its run of wins, a waiting m1/m2 takes the next grant.
    always_comb begin
        others_req = |m_arvalid[2:1];
        if (win_cnt_q == Limit && others_req) begin
            sel = m_arvalid[1] ? 2'd1 : 2'd2;
        end else if (m_arvalid[0]) begin
            sel = 2'd0;
        end else if (m_arvalid[1]) begin
            sel = 2'd1;
        end else begin
            sel = 2'd2;
        end
    end

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        win_cnt_d = win_cnt_q;
        unique case (state_q)
            StIdle: begin
                if (|m_arvalid) begin
                    state_d   = StAddr;
                    owner_d   = sel;
                    win_cnt_d = (sel == 2'd0 && others_req) ? win_cnt_q + 4'd1 : 4'd0;
                end
            end
            StAddr: if (s_arvalid && s_arready) state_d = StData;
            StData: if (s_rvalid && s_rready && s_rlast) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        owner_oh  = 3'b001 << owner_q;
        busy      = (state_q != StIdle);
        grnt      = busy ? owner_oh : 3'b000;
        s_arvalid = (state_q == StAddr) && |(m_arvalid & owner_oh);
        m_arready = (state_q == StAddr && s_arready) ? owner_oh : 3'b000;
        m_rvalid  = (state_q == StData && s_rvalid) ? owner_oh : 3'b000;
        s_rready  = (state_q == StData) && |(m_rready & owner_oh);
        m_rdata   = s_rdata;
        m_rresp   = s_rresp;
        m_rlast   = s_rlast;
    end

    // Payload follows the owner register in every state.
    always_comb begin
        case (owner_q)
            2'd1: begin
                s_araddr  = m_araddr[ADDR_W +: ADDR_W];
                s_arlen   = m_arlen[15:8];
                s_arsize  = m_arsize[5:3];
                s_arburst = m_arburst[3:2];
            end
            2'd2: begin
                s_araddr  = m_araddr[2*ADDR_W +: ADDR_W];
                s_arlen   = m_arlen[23:16];
                s_arsize  = m_arsize[8:6];
                s_arburst = m_arburst[5:4];
            end
            default: begin
                s_araddr  = m_araddr[ADDR_W-1:0];
                s_arlen   = m_arlen[7:0];
                s_arsize  = m_arsize[2:0];
                s_arburst = m_arburst[1:0];
            end
        endcase
    end

endmodule
